// File: rtl/nasti_txn_pkg.sv
// rtl/nasti_txn_pkg.sv - shared types and helpers for the NASTI transaction tracker
// Entry fields are sized for the widest supported configuration; narrower
// instances zero-extend into them so every entry compares at full width.
package nasti_txn_pkg;

    localparam int TXN_MAX_DEPTH = 16;
    localparam int TXN_IDX_W     = 4;
    localparam int TXN_ID_MAX    = 8;
    localparam int TXN_PORT_MAX  = 8;

    typedef struct packed {
        logic                    valid;
        logic [TXN_ID_MAX-1:0]   id;
        logic [TXN_PORT_MAX-1:0] port;
    } txn_entry_t;

    // One-hot of the lowest clear bit; zero when every bit is set.
    function automatic logic [TXN_MAX_DEPTH-1:0] lowest_free(input logic [TXN_MAX_DEPTH-1:0] vld);
        logic [TXN_MAX_DEPTH-1:0] oh;
        oh = '0;
        for (int i = TXN_MAX_DEPTH - 1; i >= 0; i--) begin
            if (!vld[i]) begin
                oh    = '0;
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

    function automatic logic [TXN_IDX_W-1:0] onehot_to_idx(input logic [TXN_MAX_DEPTH-1:0] oh);
        logic [TXN_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < TXN_MAX_DEPTH; i++) begin
            if (oh[i]) idx = idx | TXN_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/nasti_txn_tracker_age.sv
// rtl/nasti_txn_tracker_age.sv - age matrix selecting the oldest entry of a match vector
// Ports: clk, rstn (async active-low); set_en/set_idx mark an entry youngest;
// clr_en/clr_idx retire an entry; match in, oldest (one-hot) out.
module txn_age_matrix
    import nasti_txn_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 set_en,
    input  logic [TXN_IDX_W-1:0] set_idx,
    input  logic                 clr_en,
    input  logic [TXN_IDX_W-1:0] clr_idx,
    input  logic [DEPTH-1:0]     match,
    output logic [DEPTH-1:0]     oldest
);

    // older[i][j] = 1 means entry i was allocated before entry j.
    logic [DEPTH-1:0] older [DEPTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) older[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (clr_en && clr_idx == TXN_IDX_W'(i)) older[i][j] <= 1'b0;
                    // New entry: everyone else is older, it is older than nobody.
                    if (set_en && set_idx == TXN_IDX_W'(j) && i != j) older[i][j] <= 1'b1;
                    if (set_en && set_idx == TXN_IDX_W'(i)) older[i][j] <= 1'b0;
                end
            end
        end
    end

    // An entry wins if no other matching entry is older than it; the
    // diagonal is always zero so it never disqualifies itself.
    always_comb begin
        oldest = '0;
        for (int i = 0; i < DEPTH; i++) begin
            oldest[i] = match[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (match[j] && older[j][i]) oldest[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/nasti_txn_tracker.sv
// rtl/nasti_txn_tracker.sv - outstanding NASTI transaction table: grant throttle and response routing
// Ports: clk, rstn (async active-low); alloc_* record issued address handshakes,
// alloc_id_q/alloc_port_q feed the conflict check behind alloc_ready;
// resp_* look up and retire entries, returning resp_hit/resp_port;
// full/empty/count report occupancy; err_unmatched is a sticky error.
module nasti_txn_tracker #(
    parameter int DEPTH      = 4,
    parameter int ID_WIDTH   = 1,
    parameter int PORTS      = 8,
    parameter int PORT_WIDTH = 3
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         alloc_valid,
    input  logic [ID_WIDTH-1:0]          alloc_id,
    input  logic [PORT_WIDTH-1:0]        alloc_port,
    input  logic [ID_WIDTH-1:0]          alloc_id_q,
    input  logic [PORT_WIDTH-1:0]        alloc_port_q,
    output logic                         alloc_ready,
    input  logic                         resp_valid,
    input  logic [ID_WIDTH-1:0]          resp_id,
    input  logic                         resp_last,
    input  logic                         resp_ready,
    output logic                         resp_hit,
    output logic [PORT_WIDTH-1:0]        resp_port,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         err_unmatched
);
    import nasti_txn_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    if (PORTS > (1 << PORT_WIDTH)) begin : g_bad_port_width
        $error("PORT_WIDTH too narrow for PORTS");
    end
    if (DEPTH < 2 || DEPTH > TXN_MAX_DEPTH || ID_WIDTH > TXN_ID_MAX) begin : g_bad_size
        $error("DEPTH or ID_WIDTH out of range");
    end

    txn_entry_t               entries [DEPTH];
    logic [DEPTH-1:0]         valid_vec, match_vec, conflict_vec, oldest_oh;
    logic [TXN_MAX_DEPTH-1:0] valid_pad, oldest_pad;
    logic [TXN_IDX_W-1:0]     alloc_idx, free_idx;
    logic                     alloc_en, free_en;

    for (genvar g = 0; g < TXN_MAX_DEPTH; g++) begin : g_slot
        if (g < DEPTH) begin : g_real
            assign valid_vec[g]    = entries[g].valid;
            assign match_vec[g]    = entries[g].valid && entries[g].id == TXN_ID_MAX'(resp_id);
            assign conflict_vec[g] = entries[g].valid && entries[g].id == TXN_ID_MAX'(alloc_id_q)
                                     && entries[g].port != TXN_PORT_MAX'(alloc_port_q);
            assign valid_pad[g]    = valid_vec[g];
            assign oldest_pad[g]   = oldest_oh[g];
        end else begin : g_pad
            // Non-existent slots look occupied so they are never allocated.
            assign valid_pad[g]  = 1'b1;
            assign oldest_pad[g] = 1'b0;
        end
    end

    assign full        = (count == CNT_W'(DEPTH));
    assign empty       = (count == '0);
    assign alloc_ready = !full && !(|conflict_vec);
    assign resp_hit    = resp_valid && (|match_vec);

    // Slot choice uses pre-edge validity, so a slot freed this cycle is not reused.
    assign alloc_idx = onehot_to_idx(lowest_free(valid_pad));
    assign free_idx  = onehot_to_idx(oldest_pad);
    assign alloc_en  = alloc_valid && !full;
    assign free_en   = resp_valid && resp_ready && resp_last && resp_hit;

    txn_age_matrix #(.DEPTH(DEPTH)) u_age (
        .clk     (clk),
        .rstn    (rstn),
        .set_en  (alloc_en),
        .set_idx (alloc_idx),
        .clr_en  (free_en),
        .clr_idx (free_idx),
        .match   (match_vec),
        .oldest  (oldest_oh)
    );

    always_comb begin
        resp_port = '0;
        if (resp_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (oldest_oh[i]) resp_port = entries[i].port[PORT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (free_en && free_idx == TXN_IDX_W'(i)) entries[i].valid <= 1'b0;
                if (alloc_en && alloc_idx == TXN_IDX_W'(i)) begin
                    entries[i] <= '{valid: 1'b1,
                                    id:    TXN_ID_MAX'(alloc_id),
                                    port:  TXN_PORT_MAX'(alloc_port)};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count         <= '0;
            err_unmatched <= 1'b0;
        end else begin
            case ({alloc_en, free_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (resp_valid && !resp_hit) err_unmatched <= 1'b1;
        end
    end

endmodule
